// File: rtl/cache_pkg.sv
// Shared definitions for the cache controller and its refill engine.
//   - refill_state_e : refill FSM state encoding
//   - CACHE_ADDR_WIDTH / CACHE_LINE_SIZE : default line address / line widths
package cache_pkg;

  localparam int unsigned CACHE_ADDR_WIDTH = 8;
  localparam int unsigned CACHE_LINE_SIZE  = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    FILL = 2'd3
  } refill_state_e;

endpackage

// File: rtl/cache_refill_engine_miss_fifo.sv
// refill_miss_fifo: circular miss queue with an associative address match.
//   clk, rst   : clock, async active-high reset
//   push       : store push_data at the tail (caller guarantees !full)
//   pop        : drop the head entry (caller guarantees !empty)
//   cmp_addr   : address compared against every valid entry
//   head       : current head entry
//   empty/full : derived from pointers one bit wider than the index
//   match      : cmp_addr equals some valid entry
module refill_miss_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  input  logic [WIDTH-1:0] cmp_addr,
  output logic [WIDTH-1:0] head,
  output logic             empty,
  output logic             full,
  output logic             match
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count;

  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                 (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign head  = mem_q[rd_ptr_q[AW-1:0]];
  assign count = wr_ptr_q - rd_ptr_q;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push) begin
      mem_d[wr_ptr_q[AW-1:0]] = push_data;
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
  end

  // Slot i is live when its distance from the head is below the occupancy.
  always_comb begin
    logic [AW-1:0] off;
    match = 1'b0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      off = AW'(i) - rd_ptr_q[AW-1:0];
      if (((AW+1)'(off) < count) && (mem_q[i] == cmp_addr)) begin
        match = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

endmodule

// File: rtl/cache_refill_engine.sv
// cache_refill_engine: queues read misses (duplicates suppressed), fetches
// each line from memory one request at a time and writes it into the cache.
//   miss_valid/miss_addr/miss_ready          : miss intake from controller
//   mem_req_valid/mem_req_addr/mem_req_ready : memory fetch request
//   mem_resp_valid/mem_resp_data             : single-cycle fetch response
//   fill_wr_en/fill_addr/fill_data           : cache write port
//   timeout_err : one-cycle pulse when a request is abandoned
//   busy        : FSM active or queue non-empty
module cache_refill_engine
  import cache_pkg::*;
#(
  parameter int unsigned LINE_SIZE  = CACHE_LINE_SIZE,
  parameter int unsigned ADDR_WIDTH = CACHE_ADDR_WIDTH,
  parameter int unsigned MISS_DEPTH = 4,
  parameter int unsigned TIMEOUT    = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  miss_valid,
  input  logic [ADDR_WIDTH-1:0] miss_addr,
  output logic                  miss_ready,
  output logic                  mem_req_valid,
  output logic [ADDR_WIDTH-1:0] mem_req_addr,
  input  logic                  mem_req_ready,
  input  logic                  mem_resp_valid,
  input  logic [LINE_SIZE-1:0]  mem_resp_data,
  output logic                  fill_wr_en,
  output logic [ADDR_WIDTH-1:0] fill_addr,
  output logic [LINE_SIZE-1:0]  fill_data,
  output logic                  timeout_err,
  output logic                  busy
);

  localparam int unsigned CW = $clog2(TIMEOUT);

  refill_state_e         state_q, state_d;
  logic [ADDR_WIDTH-1:0] cur_addr_q, cur_addr_d;
  logic [LINE_SIZE-1:0]  cur_data_q, cur_data_d;
  logic [ADDR_WIDTH-1:0] fill_addr_q, fill_addr_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic                  err_q, err_d;

  logic                  q_empty, q_full, q_match, q_push, q_pop;
  logic [ADDR_WIDTH-1:0] q_head;
  logic                  dup;

  // A miss already queued or already being fetched completes its handshake
  // but is not stored again.
  assign dup    = q_match || ((state_q != IDLE) && (miss_addr == cur_addr_q));
  assign q_push = miss_valid && !q_full && !dup;

  refill_miss_fifo #(
    .WIDTH (ADDR_WIDTH),
    .DEPTH (MISS_DEPTH)
  ) u_miss_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (q_push),
    .push_data (miss_addr),
    .pop       (q_pop),
    .cmp_addr  (miss_addr),
    .head      (q_head),
    .empty     (q_empty),
    .full      (q_full),
    .match     (q_match)
  );

  always_comb begin
    state_d     = state_q;
    cur_addr_d  = cur_addr_q;
    cur_data_d  = cur_data_q;
    fill_addr_d = fill_addr_q;
    cnt_d       = cnt_q;
    err_d       = 1'b0;
    q_pop       = 1'b0;
    case (state_q)
      IDLE: begin
        if (!q_empty) begin
          q_pop      = 1'b1;
          cur_addr_d = q_head;
          state_d    = REQ;
        end
      end
      REQ: begin
        if (mem_req_ready) begin
          cnt_d   = '0;
          state_d = WAIT;
        end
      end
      WAIT: begin
        cnt_d = cnt_q + CW'(1);
        // Response takes priority over a coinciding timeout.
        if (mem_resp_valid) begin
          cur_data_d  = mem_resp_data;
          fill_addr_d = cur_addr_q;
          state_d     = FILL;
        end else if (cnt_q == CW'(TIMEOUT - 1)) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end
      end
      FILL: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cur_addr_q  <= '0;
      cur_data_q  <= '0;
      fill_addr_q <= '0;
      cnt_q       <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cur_addr_q  <= cur_addr_d;
      cur_data_q  <= cur_data_d;
      fill_addr_q <= fill_addr_d;
      cnt_q       <= cnt_d;
      err_q       <= err_d;
    end
  end

  assign miss_ready    = !q_full;
  assign mem_req_valid = (state_q == REQ);
  assign mem_req_addr  = cur_addr_q;
  assign fill_wr_en    = (state_q == FILL);
  assign fill_addr     = fill_addr_q;
  assign fill_data     = cur_data_q;
  assign timeout_err   = err_q;
  assign busy          = (state_q != IDLE) || !q_empty;

endmodule

// File: tb/tb_cache_refill_engine.sv
module tb_cache_refill_engine;

  localparam int unsigned LS = 32;
  localparam int unsigned AW = 8;
  localparam int unsigned MD = 4;
  localparam int unsigned TO = 64;

  logic          clk = 1'b0;
  logic          rst;
  logic          miss_valid;
  logic [AW-1:0] miss_addr;
  logic          miss_ready;
  logic          mem_req_valid;
  logic [AW-1:0] mem_req_addr;
  logic          mem_req_ready;
  logic          mem_resp_valid;
  logic [LS-1:0] mem_resp_data;
  logic          fill_wr_en;
  logic [AW-1:0] fill_addr;
  logic [LS-1:0] fill_data;
  logic          timeout_err;
  logic          busy;

  always #5 clk = ~clk;

  cache_refill_engine #(
    .LINE_SIZE  (LS),
    .ADDR_WIDTH (AW),
    .MISS_DEPTH (MD),
    .TIMEOUT    (TO)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .miss_valid     (miss_valid),
    .miss_addr      (miss_addr),
    .miss_ready     (miss_ready),
    .mem_req_valid  (mem_req_valid),
    .mem_req_addr   (mem_req_addr),
    .mem_req_ready  (mem_req_ready),
    .mem_resp_valid (mem_resp_valid),
    .mem_resp_data  (mem_resp_data),
    .fill_wr_en     (fill_wr_en),
    .fill_addr      (fill_addr),
    .fill_data      (fill_data),
    .timeout_err    (timeout_err),
    .busy           (busy)
  );

  int n_cmp = 0;
  int n_err = 0;

  logic [AW-1:0] hs_log[$];
  logic [AW-1:0] fa_log[$];
  logic [LS-1:0] fd_log[$];
  int            to_cnt = 0;

  // Observe handshakes, fills and timeouts mid-cycle.
  always @(negedge clk) begin
    if (!rst) begin
      if (mem_req_valid && mem_req_ready) hs_log.push_back(mem_req_addr);
      if (fill_wr_en) begin
        fa_log.push_back(fill_addr);
        fd_log.push_back(fill_data);
      end
      if (timeout_err) to_cnt++;
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] outs();
    return {11'd0, miss_ready, mem_req_valid, mem_req_addr, fill_wr_en,
            fill_addr, fill_data, busy, timeout_err};
  endfunction

  function automatic logic [63:0] pack_exp(input logic mr, input logic rqv, input logic [7:0] rqa,
                                           input logic fw, input logic [7:0] fa,
                                           input logic [31:0] fd, input logic bz, input logic te);
    return {11'd0, mr, rqv, rqa, fw, fa, fd, bz, te};
  endfunction

  function automatic logic [LS-1:0] line_of(input logic [AW-1:0] a);
    return 32'hF00D_0000 | {24'd0, a};
  endfunction

  task automatic push_miss(input logic [AW-1:0] a);
    miss_valid = 1'b1;
    miss_addr  = a;
    step();
    miss_valid = 1'b0;
  endtask

  // Wait (bounded) for a request, complete its handshake, then stall memory.
  task automatic accept_req(output logic [AW-1:0] a);
    mem_req_ready = 1'b1;
    for (int k = 0; k < 20; k++) begin
      if (mem_req_valid) break;
      step();
    end
    check("req_seen", {63'd0, mem_req_valid}, 64'd1);
    a = mem_req_addr;
    step();
    mem_req_ready = 1'b0;
  endtask

  task automatic respond(input logic [LS-1:0] d);
    mem_resp_valid = 1'b1;
    mem_resp_data  = d;
    step();
    mem_resp_valid = 1'b0;
  endtask

  task automatic run_mem(input int n, input int dly);
    logic [AW-1:0] a;
    for (int k = 0; k < n; k++) begin
      accept_req(a);
      repeat (dly) step();
      respond(line_of(a));
    end
  endtask

  function automatic void clear_logs();
    hs_log.delete();
    fa_log.delete();
    fd_log.delete();
    to_cnt = 0;
  endfunction

  typedef struct {
    logic        mv;
    logic [7:0]  ma;
    logic        rdy;
    logic        rv;
    logic [31:0] rd;
    logic        e_mr;
    logic        e_rqv;
    logic [7:0]  e_rqa;
    logic        e_fw;
    logic [7:0]  e_fa;
    logic [31:0] e_fd;
    logic        e_bz;
    logic        e_to;
  } vec_t;

  vec_t vecs[8];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [AW-1:0] a;
    logic [AW-1:0] s2a[5];
    logic [AW-1:0] exp_a;
    bit            flag;
    int            fills_before;

    rst = 1'b1; miss_valid = 1'b0; miss_addr = '0; mem_req_ready = 1'b0;
    mem_resp_valid = 1'b0; mem_resp_data = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    check("reset_state", outs(), pack_exp(1, 0, 8'h00, 0, 8'h00, 32'h0, 0, 0));

    // Single miss 0x12, ready=1, response 3 cycles after the handshake.
    vecs[0] = '{1, 8'h12, 1, 0, 32'h0,        1, 0, 8'h00, 0, 8'h00, 32'h0,        1, 0};
    vecs[1] = '{0, 8'h00, 1, 0, 32'h0,        1, 1, 8'h12, 0, 8'h00, 32'h0,        1, 0};
    vecs[2] = '{0, 8'h00, 1, 0, 32'h0,        1, 0, 8'h12, 0, 8'h00, 32'h0,        1, 0};
    vecs[3] = '{0, 8'h00, 1, 0, 32'h0,        1, 0, 8'h12, 0, 8'h00, 32'h0,        1, 0};
    vecs[4] = '{0, 8'h00, 1, 0, 32'h0,        1, 0, 8'h12, 0, 8'h00, 32'h0,        1, 0};
    vecs[5] = '{0, 8'h00, 1, 0, 32'h0,        1, 0, 8'h12, 0, 8'h00, 32'h0,        1, 0};
    vecs[6] = '{0, 8'h00, 1, 1, 32'hDEADBEEF, 1, 0, 8'h12, 1, 8'h12, 32'hDEADBEEF, 1, 0};
    vecs[7] = '{0, 8'h00, 1, 0, 32'h0,        1, 0, 8'h12, 0, 8'h12, 32'hDEADBEEF, 0, 0};
    for (int i = 0; i < 8; i++) begin
      miss_valid     = vecs[i].mv;
      miss_addr      = vecs[i].ma;
      mem_req_ready  = vecs[i].rdy;
      mem_resp_valid = vecs[i].rv;
      mem_resp_data  = vecs[i].rd;
      step();
      check($sformatf("vec%0d", i), outs(),
            pack_exp(vecs[i].e_mr, vecs[i].e_rqv, vecs[i].e_rqa, vecs[i].e_fw,
                     vecs[i].e_fa, vecs[i].e_fd, vecs[i].e_bz, vecs[i].e_to));
    end
    miss_valid = 1'b0; mem_req_ready = 1'b0; mem_resp_valid = 1'b0;
    check("single_hs_count", 64'(hs_log.size()), 64'd1);
    check("single_fill_count", 64'(fa_log.size()), 64'd1);

    // Duplicate suppression with memory stalled.
    clear_logs();
    s2a = '{8'h01, 8'h02, 8'h03, 8'h02, 8'h01};
    for (int i = 0; i < 5; i++) push_miss(s2a[i]);
    step();
    check("dup_no_hs_yet", 64'(hs_log.size()), 64'd0);
    run_mem(3, 2);
    repeat (4) step();
    check("dup_hs_count", 64'(hs_log.size()), 64'd3);
    for (int i = 0; i < 3 && i < hs_log.size(); i++)
      check($sformatf("dup_order%0d", i), 64'(hs_log[i]), 64'(i + 1));
    check("dup_idle_busy", {63'd0, busy}, 64'd0);

    // Queue full while a request sits in WAIT.
    clear_logs();
    push_miss(8'hA0);
    accept_req(a);
    for (int i = 1; i <= 4; i++) push_miss(8'(8'hA0 + i));
    check("full_ready_low", {63'd0, miss_ready}, 64'd0);
    miss_valid = 1'b1;
    miss_addr  = 8'hA5;
    flag = 1'b0;
    repeat (3) begin
      step();
      if (miss_ready) flag = 1'b1;
    end
    check("full_held", {63'd0, flag}, 64'd0);
    respond(line_of(8'hA0));
    for (int k = 0; k < 10; k++) begin
      if (miss_ready) break;
      step();
    end
    check("full_ready_back", {63'd0, miss_ready}, 64'd1);
    step();
    miss_valid = 1'b0;
    run_mem(5, 1);
    repeat (3) step();
    check("full_hs_count", 64'(hs_log.size()), 64'd6);
    check("full_fill_count", 64'(fa_log.size()), 64'd6);
    for (int i = 0; i < 6 && i < fa_log.size(); i++) begin
      exp_a = 8'(8'hA0 + i);
      check($sformatf("full_fill_addr%0d", i), 64'(fa_log[i]), 64'(exp_a));
      check($sformatf("full_fill_data%0d", i), 64'(fd_log[i]), 64'(line_of(exp_a)));
    end

    // Request held for 5 cycles with ready low.
    clear_logs();
    push_miss(8'hB0);
    for (int k = 0; k < 10; k++) begin
      if (mem_req_valid) break;
      step();
    end
    flag = 1'b1;
    repeat (5) begin
      step();
      if (!(mem_req_valid && mem_req_addr == 8'hB0)) flag = 1'b0;
    end
    check("stall_stable", {63'd0, flag}, 64'd1);
    check("stall_no_hs", 64'(hs_log.size()), 64'd0);
    mem_req_ready = 1'b1;
    step();
    mem_req_ready = 1'b0;
    step();
    check("stall_one_hs", 64'(hs_log.size()), 64'd1);
    check("stall_req_dropped", {63'd0, mem_req_valid}, 64'd0);
    respond(line_of(8'hB0));
    repeat (2) step();

    // Timeout, late response ignored, next miss proceeds.
    clear_logs();
    push_miss(8'hC0);
    push_miss(8'hC1);
    accept_req(a);
    check("to_first_addr", 64'(a), 64'hC0);
    flag = 1'b0;
    repeat (TO - 1) begin
      step();
      if (timeout_err) flag = 1'b1;
    end
    check("to_not_early", {63'd0, flag}, 64'd0);
    step();
    check("to_pulse", {63'd0, timeout_err}, 64'd1);
    step();
    check("to_one_cycle", {63'd0, timeout_err}, 64'd0);
    respond(32'hBAD0BAD0);
    repeat (2) step();
    check("to_no_fill", 64'(fa_log.size()), 64'd0);
    check("to_count", 64'(to_cnt), 64'd1);
    check("to_next_req", {55'd0, mem_req_valid, mem_req_addr}, {55'd0, 1'b1, 8'hC1});
    run_mem(1, 0);
    repeat (2) step();
    check("to_next_fill", (fa_log.size() == 1) ? 64'(fa_log[0]) : 64'hFFFF, 64'hC1);

    // Reset while in WAIT with two queued misses.
    clear_logs();
    push_miss(8'hD0);
    push_miss(8'hD1);
    push_miss(8'hD2);
    accept_req(a);
    step();
    #2 rst = 1'b1;
    #1 check("rst_async", outs(), pack_exp(1, 0, 8'h00, 0, 8'h00, 32'h0, 0, 0));
    @(posedge clk);
    #1 rst = 1'b0;
    fills_before = fa_log.size();
    respond(32'h5555AAAA);
    repeat (3) step();
    check("rst_no_fill", 64'(fa_log.size() - fills_before), 64'd0);
    check("rst_quiet", outs(), pack_exp(1, 0, 8'h00, 0, 8'h00, 32'h0, 0, 0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
